// File: rtl/periph_bus_responder.sv
// Memory-mapped timer/LED/seven-segment responder at 0x40000000; combinational read, one-cycle write.
// Optional SYSTICK free-running counter at offset 5 is built only when PERIPH_SYSTICK_EN is defined.
module periph_bus_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        Hit,
  output logic [7:0]  leds,
  output logic [11:0] digits,
  output logic        irq
);

  localparam logic [26:0] BASE_PAGE = 27'h2000000;

  logic        in_page;
  logic [2:0]  offset;
  logic        wr_en;
  logic        reload;
  logic        reload_set;
  logic [31:0] rd_val;
  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        unused_addr;

  assign unused_addr = ^Address[1:0];
  assign in_page     = (Address[31:5] == BASE_PAGE);
  assign offset      = Address[4:2];

`ifdef PERIPH_SYSTICK_EN
  logic [31:0] systick;
  assign Hit = in_page && (offset <= 3'd5);
`else
  assign Hit = in_page && (offset <= 3'd4);
`endif

  assign wr_en      = MemWrite && Hit;
  assign reload     = tcon[0] && (tl == 32'hFFFF_FFFF);
  assign reload_set = reload && tcon[1];

  always_comb begin
    rd_val = 32'h0;
    case (offset)
      3'd0: rd_val = th;
      3'd1: rd_val = tl;
      3'd2: rd_val = {29'h0, tcon};
      3'd3: rd_val = {24'h0, led};
      3'd4: rd_val = {20'h0, digi};
`ifdef PERIPH_SYSTICK_EN
      3'd5: rd_val = systick;
`endif
      default: rd_val = 32'h0;
    endcase
  end

  assign Read_data = (MemRead && Hit) ? rd_val : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th <= 32'h0;
    end else if (wr_en && offset == 3'd0) begin
      th <= Write_data;
    end
  end

  // CPU write beats the increment/reload in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tl <= 32'h0;
    end else if (wr_en && offset == 3'd1) begin
      tl <= Write_data;
    end else if (tcon[0]) begin
      tl <= reload ? th : tl + 32'd1;
    end
  end

  // A status raised by a reload survives a simultaneous CPU write of 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcon <= 3'b000;
    end else if (wr_en && offset == 3'd2) begin
      tcon <= {Write_data[2] | reload_set, Write_data[1:0]};
    end else if (reload_set) begin
      tcon[2] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led <= 8'h0;
    end else if (wr_en && offset == 3'd3) begin
      led <= Write_data[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digi <= 12'h0;
    end else if (wr_en && offset == 3'd4) begin
      digi <= Write_data[11:0];
    end
  end

`ifdef PERIPH_SYSTICK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      systick <= 32'h0;
    end else begin
      systick <= systick + 32'd1;
    end
  end
`endif

  assign irq    = tcon[1] & tcon[2];
  assign leds   = led;
  assign digits = digi;

endmodule

// File: tb/tb_periph_bus_responder.sv
// Directed self-checking bench for periph_bus_responder; inputs change just after falling edges.
module tb_periph_bus_responder;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Read_data;
  logic        Hit;
  logic [7:0]  leds;
  logic [11:0] digits;
  logic        irq;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_DIGI = 32'h4000_0010;
  localparam logic [31:0] A_SYST = 32'h4000_0014;

  periph_bus_responder dut (
    .clk        (clk),
    .reset      (reset),
    .Address    (Address),
    .Write_data (Write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Read_data  (Read_data),
    .Hit        (Hit),
    .leds       (leds),
    .digits     (digits),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Combinational read: no clock edge passes.
  task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    Address = a;
    MemRead = 1'b1;
    #1;
    chk(tag, Read_data, exp);
    MemRead = 1'b0;
  endtask

  // One rising edge carries the write; returns at the next falling edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address    = a;
    Write_data = d;
    MemWrite   = 1'b1;
    @(negedge clk);
    MemWrite   = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; Address = 32'h0; Write_data = 32'h0; MemRead = 1'b0; MemWrite = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_leds", leds, 32'h0);
    chk("rst_digits", digits, 32'h0);
    chk("rst_irq", irq, 32'h0);
    reset = 1'b1;
    chk_rd("rst_th", A_TH, 32'h0);
    chk_rd("rst_tcon", A_TCON, 32'h0);

    // Reload scenario
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFE);
    chk_rd("tl_wr", A_TL, 32'hFFFF_FFFE);
    step();
    chk_rd("tl_hold_dis", A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'h3);
    chk_rd("tl_after_en", A_TL, 32'hFFFF_FFFE);
    step();
    chk_rd("tl_inc", A_TL, 32'hFFFF_FFFF);
    chk("irq_pre", irq, 32'h0);
    step();
    chk_rd("tl_reload", A_TL, 32'hFFFF_FFFC);
    chk_rd("tcon_status", A_TCON, 32'h7);
    chk("irq_set", irq, 32'h1);

    // Clear status; counting continues
    wr(A_TCON, 32'h3);
    chk("irq_clr", irq, 32'h0);
    chk_rd("tcon_clr", A_TCON, 32'h3);
    chk_rd("tl_cont1", A_TL, 32'hFFFF_FFFD);
    step();
    chk_rd("tl_cont2", A_TL, 32'hFFFF_FFFE);
    step();
    chk_rd("tl_cont3", A_TL, 32'hFFFF_FFFF);
    // TCON write of status 0 in the reload cycle: set wins
    wr(A_TCON, 32'h3);
    chk_rd("tcon_setwins", A_TCON, 32'h7);
    chk("irq_setwins", irq, 32'h1);
    chk_rd("tl_reload2", A_TL, 32'hFFFF_FFFC);

    // TL write in reload cycle beats reload
    step(); step(); step();
    chk_rd("tl_ff_again", A_TL, 32'hFFFF_FFFF);
    wr(A_TL, 32'h5);
    chk_rd("tl_wr_prio", A_TL, 32'h5);
    wr(A_TCON, 32'h3);
    chk_rd("tl_6", A_TL, 32'h6);
    wr(A_TCON, 32'h0);
    step();
    chk_rd("tl_hold_off", A_TL, 32'h7);

    // Reload with interrupt enable off: no status
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'h1);
    chk_rd("tl_ff_noie", A_TL, 32'hFFFF_FFFF);
    step();
    chk_rd("tl_reload_noie", A_TL, 32'hFFFF_FFFC);
    chk_rd("tcon_noie", A_TCON, 32'h1);
    wr(A_TCON, 32'h0);
    chk_rd("tl_stop", A_TL, 32'hFFFF_FFFD);

    // LED / DIGI
    wr(A_LED, 32'hFFFF_FFA5);
    chk_rd("led_rd", A_LED, 32'h0000_00A5);
    chk_rd("led_rd_byte", 32'h4000_000F, 32'h0000_00A5);
    chk("leds_out", leds, 32'hA5);
    wr(A_DIGI, 32'hABCD_E123);
    chk_rd("digi_rd", A_DIGI, 32'h0000_0123);
    chk("digits_out", digits, 32'h123);
    Address = A_LED; MemRead = 1'b0; #1;
    chk("rd_noread", Read_data, 32'h0);
    chk("hit_led", Hit, 32'h1);

    // Unmapped / out of page
    chk_rd("rd_unmapped", 32'h4000_0018, 32'h0);
    chk("hit_unmapped", Hit, 32'h0);
    Address = 32'h4000_0020; #1;
    chk("hit_nextpage", Hit, 32'h0);
    Address = 32'h5000_0000; #1;
    chk("hit_other", Hit, 32'h0);
`ifdef PERIPH_SYSTICK_EN
    Address = A_SYST; #1;
    chk("hit_systick", Hit, 32'h1);
`else
    chk_rd("rd_systick_off", A_SYST, 32'h0);
    chk("hit_systick_off", Hit, 32'h0);
`endif
    step();
    wr(32'h4000_001C, 32'hFFFF_FFFF);
    chk_rd("unm_th", A_TH, 32'hFFFF_FFFC);
    chk_rd("unm_tl", A_TL, 32'hFFFF_FFFD);
    chk_rd("unm_led", A_LED, 32'h0000_00A5);
    chk_rd("unm_digi", A_DIGI, 32'h0000_0123);
    step();
    wr(A_SYST, 32'h1234_5678);
    chk_rd("unm_tcon", A_TCON, 32'h0);

    // Simultaneous read and write returns the old value
    Address = A_LED; Write_data = 32'h3C; MemRead = 1'b1; MemWrite = 1'b1; #1;
    chk("rdw_old", Read_data, 32'h0000_00A5);
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    chk_rd("rdw_new", A_LED, 32'h0000_003C);

    // Reset mid-count
    wr(A_TL, 32'h100);
    wr(A_TCON, 32'h7);
    chk("irq_swset", irq, 32'h1);
    step(); step();
    chk_rd("tl_count", A_TL, 32'h102);
    #2 reset = 1'b0;
    #1;
    chk("async_irq", irq, 32'h0);
    chk("async_leds", leds, 32'h0);
    chk("async_digits", digits, 32'h0);
    chk_rd("async_tl", A_TL, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
`ifdef PERIPH_SYSTICK_EN
    chk_rd("systick0", A_SYST, 32'h0);
`endif
    step(); step(); step();
    chk_rd("tl_frozen", A_TL, 32'h0);
    chk_rd("tcon_after", A_TCON, 32'h0);
    chk_rd("th_after", A_TH, 32'h0);
`ifdef PERIPH_SYSTICK_EN
    chk_rd("systick3", A_SYST, 32'h3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/periph_bus_responder.md
PERIPH_BUS_RESPONDER -- requirements
Module: periph_bus_responder

Interface
REQ-001 The block SHALL use one clock and SHALL take an asynchronous, active-low reset; the clock and reset ports are named clk and reset.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Address  in  32  byte address from the CPU.
- Write_data  in  32  store data from the CPU.
- MemRead  in  1  read strobe.
- MemWrite  in  1  write strobe.
- Read_data  out  32  load data returned to the CPU.
- Hit  out  1  the Address decodes to a mapped register.
- leds  out  8  LED drive.
- digits  out  12  seven-segment drive: [11:8] anode enables, [7:0] segments.
- irq  out  1  timer interrupt request.

Function
REQ-003 Decode SHALL use Address[31:5]==27'h2000000 (base 0x40000000) and Address[4:2] as the word offset; Address[1:0] SHALL be ignored.
REQ-004 The register map SHALL be:
- 0 TH (32 bits)
- 1 TL (32 bits)
- 2 TCON (bits [2:0]: [0] enable, [1] interrupt enable, [2] status)
- 3 LED (8 bits)
- 4 DIGI (12 bits)
- 5 SYSTICK (32 bits, read-only)
Offsets 6-7 SHALL be unmapped.
REQ-005 Hit SHALL be combinational and SHALL be 1 for offsets 0-5 within the base page.
REQ-006 Read_data SHALL be combinational, valid in the same cycle as MemRead=1 with stable Address. It SHALL be zero-extended register contents on a hit, and 32'h0 when MemRead=0 or when there is no hit.
REQ-007 A write SHALL occur at the rising edge when MemWrite=1 and Hit=1; a write latency of one cycle is visible on the next read.
REQ-008 Writes to unmapped offsets and to SYSTICK SHALL have no effect.
REQ-009 When MemRead and MemWrite are both 1, the read SHALL return the pre-write value.
REQ-010 Timer, each cycle with TCON[0]=1:
- TL<=TL+1 when TL!=32'hFFFFFFFF.
- TL<=TH when TL==32'hFFFFFFFF (wrap-around reload).
- On reload, TCON[2]<=1 if TCON[1]=1.
REQ-011 With TCON[0]=0, TL SHALL hold its value.
REQ-012 A CPU write to TL SHALL take priority over the increment or reload in the same cycle.
REQ-013 A CPU write to TCON in the reload cycle SHALL take priority, except that a status set by the reload SHALL survive a write of TCON[2]=0 in that cycle (set wins).
REQ-014 TCON[2] SHALL be cleared only by a CPU write of 0 to bit 2 in a cycle without a reload.
REQ-015 irq SHALL equal TCON[1]&TCON[2] and SHALL be combinational from registers.
REQ-016 leds and digits SHALL be driven directly from the LED and DIGI registers.

Reset
REQ-017 When reset=0, asynchronously, the block SHALL set TH, TL, TCON, LED, DIGI and SYSTICK to 0, giving irq=0, leds=0 and digits=0.
REQ-018 Reset asserted mid-count SHALL abort the count immediately.
REQ-019 After reset is released, counting SHALL resume only after software writes TCON[0]=1.

Configuration
REQ-020 Macro PERIPH_SYSTICK_EN SHALL control the SYSTICK register.
- Defined: SYSTICK increments every cycle out of reset, wrapping from 32'hFFFFFFFF to 0.
- Undefined: no counter is built, offset 5 reads 0, and Hit is 0 for offset 5.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Write TH=32'hFFFFFFFC, TL=32'hFFFFFFFE, TCON=3'b011 -> 2 cycles later TL=32'hFFFFFFFC, TCON[2]=1, irq=1.
- With irq=1, write TCON=3'b011 -> irq=0 next cycle; TL continues counting.
- Write TL=5 in a reload cycle -> TL reads 5, not TH.
- Write LED=8'hA5 then read 0x4000000C -> Read_data=32'h000000A5, leds=8'hA5.
- Read 0x40000018 and write 0x4000001C -> Read_data=0, Hit=0, no register change.
- Drop reset during count -> all outputs 0 at once; TL frozen at 0 after release. With PERIPH_SYSTICK_EN, SYSTICK reads 0 then N after N cycles.
